// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared FSM state type and register-index width for the hazard controller
package pipe_hazard_ctrl_pkg;
  localparam int REG_ADDR_BITS = 5;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} phc_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// pipe_hazard_ctrl_load_use_detect: flags a load in EX whose non-x0 destination feeds either ID source
import pipe_hazard_ctrl_pkg::*;
module pipe_hazard_ctrl_load_use_detect #(
  parameter int W = REG_ADDR_BITS
) (
  input  logic [W-1:0] ex_rd,
  input  logic [W-1:0] id_rs1,
  input  logic [W-1:0] id_rs2,
  input  logic         ex_mem_read,
  output logic         load_use
);
  assign load_use = ex_mem_read && ex_rd != '0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for IF_ID/ID_EX/EX_MEM/MEM_WB with data-memory wait timeout; HAZARD_PERF_EN adds stall_cnt/flush_cnt
import pipe_hazard_ctrl_pkg::*;
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = REG_ADDR_BITS,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_access,
  input  logic                  dm_ready,
  output logic                  dm_req,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  mem_wb_flush,
  output logic                  mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  phc_state_t    state, state_nx;
  logic [CW-1:0] wait_cnt, cnt_nx;
  logic [4:0]    en;
  logic [2:0]    fl;
  logic          load_use;
  pipe_hazard_ctrl_load_use_detect #(.W(REG_ADDR_W)) u_lud (
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );
  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en;
  assign {if_id_flush, id_ex_flush, mem_wb_flush} = fl;
  assign mem_err = state == ERR;
  always_comb begin
    en       = '0;
    fl       = 3'b111;
    dm_req   = 1'b0;
    state_nx = state;
    cnt_nx   = wait_cnt;
    if (!rst)
      unique case (state)
        RUN: begin
          dm_req = mem_access;
          if (mem_access && !dm_ready) begin
            en       = '0;
            fl       = 3'b001;
            state_nx = MEM_WAIT;
            cnt_nx   = CW'(1);
          end else if (ex_branch_taken) begin
            en = '1;
            fl = 3'b110;
          end else if (load_use) begin
            en = 5'b00111;
            fl = 3'b010;
          end else begin
            en = '1;
            fl = '0;
          end
        end
        MEM_WAIT: begin
          dm_req   = 1'b1;
          en       = {5{dm_ready}};
          fl       = {2'b00, !dm_ready};
          state_nx = dm_ready ? RUN : wait_cnt == CW'(MEM_TIMEOUT) ? ERR : MEM_WAIT;
          cnt_nx   = dm_ready ? '0 : wait_cnt + CW'(wait_cnt != '1);
        end
        default: begin
          en       = '0;
          fl       = 3'b001;
          state_nx = ERR;
        end
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= cnt_nx;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(!pc_en);
      flush_cnt <= flush_cnt + 32'(if_id_flush && state == RUN);
    end
  end
`endif
endmodule
